// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round count and round-constant lookup
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // Round constant for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 sits in the top byte, so byte i lives at bit offset (255 - i) * 8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 key schedule, one round key written per cycle
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         co_n_rst,
  input  logic         key_en,
  input  logic [127:0] key,
  output logic         rk_we,
  output logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic [127:0] final_key,
  output logic         busy,
  output logic         key_d
);

  state_t state, state_nx;
  logic         rst_ok;
  logic [3:0]   round, round_nx;
  logic         rk_we_nx, busy_nx, key_d_nx;
  logic [3:0]   rk_addr_nx;
  logic [127:0] rk_data_nx, final_key_nx;
  logic [31:0]  w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;

  assign rst_ok = n_rst & co_n_rst;

  // Next round key derived from the key currently on rk_data.
  assign {w0, w1, w2, w3} = rk_data;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = sub ^ {rcon(round), 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  aes_sbox u_sbox0 (.din(rot[31:24]), .dout(sub[31:24]));
  aes_sbox u_sbox1 (.din(rot[23:16]), .dout(sub[23:16]));
  aes_sbox u_sbox2 (.din(rot[15:8]),  .dout(sub[15:8]));
  aes_sbox u_sbox3 (.din(rot[7:0]),   .dout(sub[7:0]));

  always_ff @(posedge clk) begin
    if (!rst_ok) state <= IDLE;
    else         state <= state_nx;
  end

  // round exceeds NUM_ROUNDS only on the edge after the last write.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key_en) state_nx = EXPAND;
      EXPAND:  if (round > NUM_ROUNDS) state_nx = DONE;
      DONE:    if (!key_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    round_nx     = round;
    rk_we_nx     = 1'b0;
    rk_addr_nx   = rk_addr;
    rk_data_nx   = rk_data;
    final_key_nx = final_key;
    busy_nx      = busy;
    key_d_nx     = key_d;
    case (state)
      IDLE: begin
        if (key_en) begin
          rk_data_nx = key;
          rk_addr_nx = 4'd0;
          rk_we_nx   = 1'b1;
          busy_nx    = 1'b1;
          round_nx   = 4'd1;
        end
      end
      EXPAND: begin
        if (round <= NUM_ROUNDS) begin
          rk_data_nx = {n0, n1, n2, n3};
          rk_addr_nx = round;
          rk_we_nx   = 1'b1;
          round_nx   = round + 4'd1;
          if (round == NUM_ROUNDS) final_key_nx = {n0, n1, n2, n3};
        end else begin
          busy_nx  = 1'b0;
          key_d_nx = 1'b1;
        end
      end
      DONE: begin
        busy_nx = 1'b0;
        if (!key_en) begin
          key_d_nx = 1'b0;
          round_nx = 4'd0;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        key_d_nx = 1'b0;
        round_nx = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ok) begin
      round     <= 4'd0;
      rk_we     <= 1'b0;
      rk_addr   <= 4'd0;
      rk_data   <= '0;
      final_key <= '0;
      busy      <= 1'b0;
      key_d     <= 1'b0;
    end else begin
      round     <= round_nx;
      rk_we     <= rk_we_nx;
      rk_addr   <= rk_addr_nx;
      rk_data   <= rk_data_nx;
      final_key <= final_key_nx;
      busy      <= busy_nx;
      key_d     <= key_d_nx;
    end
  end

endmodule
